rr_lock_arbiter: RTL and testbench

- N-requester round-robin arbiter with grant locking for a shared multi-cycle resource (bus, memory port, shared datapath).
- A requester keeps its grant for as long as it holds its request. Ownership passes in rotating order.
- An optional hold limit preempts long owners, so no requester starves.
- Sits between requester clients and the shared resource. Downstream muxing is driven by grants and grant_id.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 44 ++++
 rtl/rr_lock_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_lock_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Bit width needed to hold an index in [0, n-1]; never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping past the top index. Returns one-hot, index and "any" flag.
module rr_priority_pick import arb_pkg::*; #(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;
  logic               found;

  // Rotate the doubled vector so ptr_i lands at bit 0, find the lowest set
  // bit, then map the offset back to an absolute index modulo N_REQ.
  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    idx_o  = sum[IW-1:0];
    pick_o = found ? (N_REQ'(1) << sum[IW-1:0]) : '0;
    any_o  = found;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking. An owner keeps the grant while it
// holds its request; ownership rotates from the index after the last grant.
// Optional hold limit (define RR_LOCK_ARB_HOLD_LIMIT_EN) preempts an owner
// after MAX_HOLD consecutive cycles when another requester is waiting.
module rr_lock_arbiter import arb_pkg::*; #(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int IW       = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] requests,
  output logic [N_REQ-1:0] grants,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("rr_lock_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("rr_lock_arbiter: MAX_HOLD must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grants_q, grants_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             take_pick;

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  localparam int          HW       = idx_w(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  logic          others_pending;
`endif

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i  (requests),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state: decide whether to keep, hand over, preempt or go idle.
  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    take_pick = 1'b0;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    hold_d         = hold_q;
    others_pending = |(requests & ~grants_q);
`endif
    case (state_q)
      IDLE: begin
        take_pick = pick_any;
      end
      BUSY: begin
        if (!requests[id_q]) begin
          // Release: hand over in the same edge, or fall idle.
          if (pick_any) begin
            take_pick = 1'b1;
          end else begin
            state_d  = IDLE;
            grants_d = '0;
            valid_d  = 1'b0;
            id_d     = '0;
          end
        end else begin
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
          // Owner still requesting: count up, or preempt once the limit is
          // reached and someone else waits. The owner sits last in the scan
          // because ptr already points one past it.
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end else if (others_pending) begin
            take_pick = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take_pick) begin
      state_d  = BUSY;
      grants_d = pick;
      valid_d  = 1'b1;
      id_d     = pick_idx;
      ptr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_d   = HW'(1);
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grants_q <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      ptr_q    <= '0;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign grants      = grants_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter (N_REQ=4, MAX_HOLD=3). Follows the build's
// RR_LOCK_ARB_HOLD_LIMIT_EN setting. A driver applies requests and pushes
// the reference model's expected outputs; a monitor pops and compares.
module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int MH = 3;

  typedef struct packed {
    logic [N-1:0] g;
    logic         v;
    logic [1:0]   id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] requests;
  logic [N-1:0] grants;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  // Reference model state: owner index (-1 = none), scan start, hold count.
  int owner = -1;
  int mptr  = 0;
  int mhold = 0;

  rr_lock_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .requests    (requests),
    .grants      (grants),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic grant_to(input int k);
    owner = k;
    mptr  = (k + 1) % N;
    mhold = 1;
  endtask

  task automatic model_step(input logic r_rst, input logic [N-1:0] r);
    int k;
    k = rr_pick(r, mptr);
    if (r_rst) begin
      owner = -1; mptr = 0; mhold = 0;
    end else if (owner < 0) begin
      if (k >= 0) grant_to(k);
    end else if (!r[owner]) begin
      if (k >= 0) grant_to(k);
      else owner = -1;
    end else begin
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      if (mhold < MH) mhold++;
      else if ((r & ~(4'b1 << owner)) != 0) grant_to(k);
`endif
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g  = (owner >= 0) ? (4'b1 << owner) : 4'b0;
    e.v  = (owner >= 0);
    e.id = (owner >= 0) ? 2'(owner) : 2'd0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus, then record what the model says the DUT
  // must show after this edge.
  task automatic drive(input logic r_rst, input logic [N-1:0] r);
    @(negedge clk);
    rst      = r_rst;
    requests = r;
    @(posedge clk);
    model_step(r_rst, r);
    expq.push_back(model_out());
  endtask

  // Directed spot check of grants a little after the edge just driven.
  task automatic spot(input string name, input logic [N-1:0] g_req);
    #2;
    check(name, int'(grants), int'(g_req));
  endtask

  // Monitor: outputs are valid every cycle; compare against the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("grants", int'(grants), int'(e.g));
      check("grant_valid", int'(grant_valid), int'(e.v));
      check("grant_id", int'(grant_id), int'(e.id));
    end
  end

  initial begin
    logic [N-1:0] r;
    rst      = 1'b1;
    requests = '0;

    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    spot("reset_grants", 4'b0000);

    drive(1'b0, 4'b0110);
    spot("first_grant", 4'b0010);
    check("first_id", int'(grant_id), 1);
    drive(1'b0, 4'b0100);
    spot("handoff_no_bubble", 4'b0100);
    drive(1'b0, 4'b0000);
    spot("idle_after_release", 4'b0000);
    check("idle_valid", int'(grant_valid), 0);

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 4'b0011);
      spot("preempt_rotation", ((i / 3) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
`else
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b0011);
      spot("lock_no_preempt", 4'b0001);
    end
    drive(1'b0, 4'b0010);
    spot("lock_release", 4'b0010);
`endif
    drive(1'b0, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b1000);
      spot("alone_saturate", 4'b1000);
    end
    drive(1'b0, 4'b0101);
    spot("wrap_to_0", 4'b0001);
    drive(1'b0, 4'b0100);
    spot("after_wrap", 4'b0100);
    drive(1'b1, 4'b0100);
    spot("reset_mid_own", 4'b0000);
    drive(1'b0, 4'b0110);
    spot("ptr_restart", 4'b0010);

    // Randomized traffic: level requests that toggle occasionally so owners
    // hold for several cycles, with rare resets.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
      end
      drive(($urandom_range(0, 299) == 0), r);
    end
    drive(1'b0, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
